// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sequencing N_REQ requesters onto one registered ALU
module alu_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ALU_LAT = 1,
    localparam int IDW    = $clog2(N_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [4*N_REQ-1:0] req_a_i,
    input  logic [4*N_REQ-1:0] req_b_i,
    input  logic [2*N_REQ-1:0] req_op_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [N_REQ-1:0]   resp_valid_o,
    output logic [4:0]         resp_data_o,
    output logic [IDW-1:0]     grant_id_o,
    output logic               busy_o,
    output logic [3:0]         alu_a_o,
    output logic [3:0]         alu_b_o,
    output logic [1:0]         alu_opcode_o,
    input  logic [4:0]         alu_c_i
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    state_t             state_q;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     grant_q;
    logic [2:0]         cnt_q;
    logic [N_REQ-1:0]   resp_valid_q;
    logic [4:0]         resp_data_q;
    logic               busy_q;
    logic [3:0]         alu_a_q;
    logic [3:0]         alu_b_q;
    logic [1:0]         alu_op_q;

    logic               win_found;
    logic [IDW-1:0]     win_idx;
    logic [IDW-1:0]     cand;

    // Round-robin pick: first pending requester after the last winner, wrapping around
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % N_REQ);
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Acceptance is only offered while idle; reset forces it low with everything else
    always_comb begin
        req_ready_o = '0;
        if (rst_ni && state_q == S_IDLE && win_found) begin
            req_ready_o = ONE << win_idx;
        end
    end

    // Sequencer: issue to the ALU, count out its latency, then strobe the response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            ptr_q        <= IDW'(N_REQ - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            busy_q       <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        alu_a_q  <= req_a_i[{win_idx, 2'b00} +: 4];
                        alu_b_q  <= req_b_i[{win_idx, 2'b00} +: 4];
                        alu_op_q <= req_op_i[{win_idx, 1'b0} +: 2];
                        ptr_q    <= win_idx;
                        grant_q  <= win_idx;
                        cnt_q    <= 3'(ALU_LAT);
                        busy_q   <= 1'b1;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        resp_data_q  <= alu_c_i;
                        resp_valid_q <= ONE << grant_q;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_RESP: begin
                    resp_valid_q <= '0;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    resp_valid_q <= '0;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign grant_id_o   = grant_q;
    assign busy_o       = busy_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_opcode_o = alu_op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a registered bench-side ALU
module tb_alu_arbiter;

    localparam int N   = 4;
    localparam int LAT = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]   req_valid = '0;
    logic [4*N-1:0] req_a     = '0;
    logic [4*N-1:0] req_b     = '0;
    logic [2*N-1:0] req_op    = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [4:0]     resp_data;
    logic [1:0]     grant_id;
    logic           busy;
    logic [3:0]     alu_a;
    logic [3:0]     alu_b;
    logic [1:0]     alu_op;
    logic [4:0]     alu_c = '0;

    logic [N-1:0]   r3_valid = '0;
    logic [4*N-1:0] r3_a     = '0;
    logic [4*N-1:0] r3_b     = '0;
    logic [2*N-1:0] r3_op    = '0;
    logic [N-1:0]   q3_ready;
    logic [N-1:0]   q3_valid;
    logic [4:0]     q3_data;
    logic [1:0]     q3_gid;
    logic           q3_busy;
    logic [3:0]     q3_a;
    logic [3:0]     q3_b;
    logic [1:0]     q3_op;
    logic [4:0]     p0 = '0, p1 = '0, p2 = '0;

    alu_arbiter #(.N_REQ(N), .ALU_LAT(LAT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
        .req_ready_o(req_ready), .resp_valid_o(resp_valid), .resp_data_o(resp_data),
        .grant_id_o(grant_id), .busy_o(busy),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_opcode_o(alu_op), .alu_c_i(alu_c)
    );

    alu_arbiter #(.N_REQ(N), .ALU_LAT(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(r3_valid), .req_a_i(r3_a), .req_b_i(r3_b), .req_op_i(r3_op),
        .req_ready_o(q3_ready), .resp_valid_o(q3_valid), .resp_data_o(q3_data),
        .grant_id_o(q3_gid), .busy_o(q3_busy),
        .alu_a_o(q3_a), .alu_b_o(q3_b), .alu_opcode_o(q3_op), .alu_c_i(p2)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    // Bench ALUs: one register stage for the main DUT, three for the long-latency one
    always @(posedge clk) begin
        alu_c <= alu_f(alu_a, alu_b, alu_op);
        p0    <= alu_f(q3_a, q3_b, q3_op);
        p1    <= p0;
        p2    <= p1;
    end

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         id;
        logic [4:0] data;
        longint     due;
    } ent_t;
    ent_t sb[$];

    // Reference model: one operation at a time, each occupying LAT+3 cycles from acceptance
    int          mptr    = N - 1;
    longint      free_at = 0;
    longint      last_acc = 0;
    bit          had_acc = 1'b0;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] hs_seen = '0;
    int          w;
    int          c;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            mptr    = N - 1;
            free_at = 0;
            had_acc = 1'b0;
            hs_seen = '0;
        end else begin
            exp_rdy = '0;
            hs_seen = req_ready & req_valid;
            if (cyc >= free_at && req_valid != '0) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (mptr + k) % N;
                    if (w < 0 && req_valid[c]) w = c;
                end
                exp_rdy[w] = 1'b1;
                sb.push_back('{w, alu_f(req_a[4*w +: 4], req_b[4*w +: 4], req_op[2*w +: 2]), cyc + LAT + 2});
                mptr     = w;
                last_acc = cyc;
                free_at  = cyc + LAT + 3;
                had_acc  = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(had_acc && cyc > last_acc && cyc < free_at));
            if (had_acc && cyc == last_acc + 1) chk("grant_id", 32'(grant_id), 32'(mptr));
        end
    end

    // Monitor: every response strobe is matched against the oldest expected entry
    ent_t e;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("resp_valid_in_reset", 32'(resp_valid), 32'd0);
        end else if (resp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_onehot", 32'(resp_valid), 32'(1) << e.id);
                chk("resp_data", 32'(resp_data), 32'(e.data));
                chk("resp_cycle", 32'(cyc), 32'(e.due));
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            chk("missing_resp", 32'(resp_valid), 32'(1) << sb[0].id);
            void'(sb.pop_front());
        end
    end

    task automatic put(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        req_valid[i]      = 1'b1;
        req_a[4*i +: 4]   = a;
        req_b[4*i +: 4]   = b;
        req_op[2*i +: 2]  = op;
    endtask

    task automatic step(input bit rnd, input logic [N-1:0] keep);
        bit withdrawn;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            withdrawn = 1'b0;
            if (req_valid[i] && hs_seen[i]) begin
                req_valid[i] = 1'b0;
            end else if (rnd && req_valid[i] && $urandom_range(0, 15) == 0) begin
                req_valid[i] = 1'b0;
                withdrawn    = 1'b1;
            end
            if (!req_valid[i] && !withdrawn && (keep[i] || (rnd && $urandom_range(0, 3) == 0)))
                put(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end
    endtask

    task automatic run(input int n, input bit rnd, input logic [N-1:0] keep);
        for (int k = 0; k < n; k++) step(rnd, keep);
    endtask

    task automatic wait_hs(input int i);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i] && req_valid[i]) got = 1'b1;
        end
        chk("handshake_timeout", 32'(got), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_data"}, 32'(resp_data), 32'd0);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int k3;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        put(0, 4'd2, 4'd1, 2'b00);
        run(10, 1'b0, '0);
        put(0, 4'd15, 4'd15, 2'b00);
        run(10, 1'b0, '0);

        pulse_reset();
        for (int i = 0; i < N; i++) put(i, 4'(i + 1), 4'(2 * i + 3), 2'(i));
        run(24, 1'b0, '0);

        run(40, 1'b0, 4'b0101);
        run(16, 1'b0, '0);

        run(600, 1'b1, '0);
        run(20, 1'b0, '0);

        put(0, 4'd7, 4'd6, 2'b00);
        wait_hs(0);
        step(1'b0, '0);
        #1 rst_n = 1'b0;
        #1 check_zero("midreset");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        put(1, 4'd9, 4'd4, 2'b01);
        wait_hs(1);
        @(posedge clk);
        #1 chk("post_reset_grant", 32'(grant_id), 32'd1);
        req_valid[1] = 1'b0;
        run(12, 1'b0, '0);

        r3_valid[2]   = 1'b1;
        r3_a[8 +: 4]  = 4'd5;
        r3_b[8 +: 4]  = 4'd9;
        r3_op[4 +: 2] = 2'b01;
        k3 = 0;
        for (int k = 0; k < 12 && k3 == 0; k++) begin
            @(negedge clk);
            if (q3_ready[2]) k3 = 1;
        end
        chk("lat3_accept", 32'(k3), 32'd1);
        @(posedge clk);
        #1 r3_valid = '0;
        k3 = 0;
        for (int k = 1; k <= 8 && k3 == 0; k++) begin
            @(negedge clk);
            if (q3_valid != '0) begin
                k3 = k;
            end else if (k <= 4) begin
                chk("lat3_alu_a", 32'(q3_a), 32'd5);
                chk("lat3_alu_b", 32'(q3_b), 32'd9);
                chk("lat3_alu_op", 32'(q3_op), 32'd1);
            end
        end
        chk("lat3_resp_cycle", 32'(k3), 32'd5);
        chk("lat3_resp_valid", 32'(q3_valid), 32'b0100);
        chk("lat3_resp_data", 32'(q3_data), 32'd28);
        run(4, 1'b0, '0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
